// File: rtl/instr_prefetch.sv
// instr_prefetch: owns the PC, fetches from the ROM and queues words for decode.
// Optional INSTR_PREFETCH_BYPASS_EN: the ROM word goes straight out when the queue is empty.
module instr_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 32,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] pc;
    logic [AW-1:0] mem_pc    [DEPTH];
    logic [DW-1:0] mem_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic empty;
    logic full;
    logic byp;
    logic byp_take;
    logic deq;
    logic fifo_deq;
    logic enq;

    assign rom_addr = pc;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

`ifdef INSTR_PREFETCH_BYPASS_EN
    assign byp = empty & ~redirect_valid;
`else
    assign byp = 1'b0;
`endif

    // Bypassed words go to the consumer without touching the queue.
    assign deq      = out_valid & out_ready;
    assign byp_take = byp & out_ready;
    assign fifo_deq = deq & ~byp_take;
    assign enq      = ~redirect_valid & ~byp_take & (~full | deq);

    // Head entry from storage, or the live ROM word when bypassing.
    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_pc    = '0;
        if (!empty) begin
            out_valid = 1'b1;
            out_instr = mem_instr[rd_ptr];
            out_pc    = mem_pc[rd_ptr];
        end else if (byp) begin
            out_valid = 1'b1;
            out_instr = rom_data;
            out_pc    = pc;
        end
    end

    // PC, pointers and occupancy; redirect flushes and overrides everything else.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc     <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq || byp_take) pc <= pc + AW'(1);
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (fifo_deq) rd_ptr <= rd_ptr + PW'(1);
            if (enq && !fifo_deq) count <= count + CW'(1);
            else if (!enq && fifo_deq) count <= count - CW'(1);
        end
    end

    // Queue storage; contents are meaningless outside the valid window.
    always_ff @(posedge CLK) begin
        if (enq) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= rom_data;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: vector table, directed corner sequences and a
// queue-based reference model driven by random consumer back-pressure.
module tb_instr_prefetch;

    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [CW-1:0] count;

    logic [DW-1:0] rom [8];
    assign rom_data = rom[rom_addr];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rdy;
        logic       rv;
        logic [2:0] rpc;
        logic       ev;
        logic [2:0] epc;
        logic [2:0] ecnt;
        logic [2:0] eaddr;
    } vec_t;

    vec_t tbl [13];

    logic [2:0] mq [$];
    logic [2:0] mpc;

    instr_prefetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset(input logic rdy);
        RST_N          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = rdy;
        step();
        RST_N = 1'b1;
    endtask

    task automatic expect_out(input string nm, input logic ev,
                              input logic [2:0] epc, input logic [2:0] ecnt,
                              input logic [2:0] eaddr);
        logic [31:0] ei;
        ei = ev ? rom[epc] : 32'h0;
        chk({nm, "_valid"}, 32'(out_valid), 32'(ev));
        chk({nm, "_pc"}, 32'(out_pc), 32'(ev ? epc : 3'd0));
        chk({nm, "_instr"}, out_instr, ei);
        chk({nm, "_count"}, 32'(count), 32'(ecnt));
        chk({nm, "_addr"}, 32'(rom_addr), 32'(eaddr));
    endtask

    task automatic model_check();
        int         sz;
        logic       ev;
        logic [2:0] epc;
        sz  = mq.size();
        ev  = (sz > 0);
        epc = (sz > 0) ? mq[0] : 3'd0;
`ifdef INSTR_PREFETCH_BYPASS_EN
        if (sz == 0 && !redirect_valid) begin
            ev  = 1'b1;
            epc = mpc;
        end
`endif
        chk("rnd_valid", 32'(out_valid), 32'(ev));
        chk("rnd_pc", 32'(out_pc), 32'(ev ? epc : 3'd0));
        chk("rnd_instr", out_instr, ev ? rom[epc] : 32'h0);
        chk("rnd_count", 32'(count), 32'(sz));
        chk("rnd_addr", 32'(rom_addr), 32'(mpc));
        chk("rnd_count_max", 32'(count <= 3'd4), 32'd1);
    endtask

    task automatic model_edge();
        int  sz;
        bit  took;
        bit  d;
        sz   = mq.size();
        took = 1'b0;
        if (!RST_N) begin
            mq.delete();
            mpc = 3'd0;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = redirect_pc;
        end else begin
`ifdef INSTR_PREFETCH_BYPASS_EN
            if (sz == 0 && out_ready) begin
                mpc  = mpc + 3'd1;
                took = 1'b1;
            end
`endif
            if (!took) begin
                d = (sz > 0) && out_ready;
                if (d) void'(mq.pop_front());
                if (sz < DEPTH || d) begin
                    mq.push_back(mpc);
                    mpc = mpc + 3'd1;
                end
            end
        end
    endtask

    initial begin
        rom[0] = 32'hD82C07CD;
        rom[1] = 32'h6BAA9455;
        rom[2] = 32'h13579BDF;
        rom[3] = 32'h2468ACE0;
        rom[4] = 32'hDEADBEEF;
        rom[5] = 32'h0BADF00D;
        rom[6] = 32'h5A5AA5A5;
        rom[7] = 32'hC17C6279;

        //            rdy   rv    rpc   ev    epc   cnt   addr
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 3'd1, 3'd1};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 3'd2, 3'd2};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 3'd2, 3'd3};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 3'd3, 3'd4};
        tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 3'd4, 3'd5};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 3'd4, 3'd5};
        tbl[7]  = '{1'b1, 1'b1, 3'd6, 1'b1, 3'd1, 3'd4, 3'd5};
        tbl[8]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd6};
        tbl[9]  = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 3'd1, 3'd7};
        tbl[10] = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 3'd1, 3'd0};
        tbl[11] = '{1'b1, 1'b1, 3'd2, 1'b1, 3'd0, 3'd1, 3'd1};
        tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd2};

        RST_N          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();

        // Reset state while reset is still held
        @(negedge CLK);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
`ifndef INSTR_PREFETCH_BYPASS_EN
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_instr", out_instr, 32'h0);
`endif
        step();
        RST_N = 1'b1;

`ifndef INSTR_PREFETCH_BYPASS_EN
        for (int i = 0; i < 13; i++) begin
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(negedge CLK);
            expect_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].epc,
                       tbl[i].ecnt, tbl[i].eaddr);
            step();
        end
        redirect_valid = 1'b0;

        // Streaming after reset: pc 0..7,0 back to back
        apply_reset(1'b1);
        out_ready = 1'b1;
        @(negedge CLK);
        chk("stream_first_empty", 32'(out_valid), 32'd0);
        step();
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            chk($sformatf("stream%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d_pc", k), 32'(out_pc), 32'(k % 8));
            chk($sformatf("stream%0d_instr", k), out_instr, rom[3'(k % 8)]);
            step();
        end

        // Back-pressure: saturate, then drain without gaps
        apply_reset(1'b0);
        repeat (10) step();
        @(negedge CLK);
        chk("sat_count", 32'(count), 32'd4);
        chk("sat_addr", 32'(rom_addr), 32'd4);
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_pc", k), 32'(out_pc), 32'(k));
            step();
        end

        // Redirect to 7 at full, coinciding with a dequeue
        apply_reset(1'b0);
        repeat (5) step();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 3'd7;
        @(negedge CLK);
        chk("redir_full_count", 32'(count), 32'd4);
        chk("redir_full_valid", 32'(out_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        @(negedge CLK);
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_addr", 32'(rom_addr), 32'd7);
        chk("redir_empty", 32'(out_valid), 32'd0);
        step();
        out_ready = 1'b1;
        @(negedge CLK);
        chk("redir_w7_valid", 32'(out_valid), 32'd1);
        chk("redir_w7_pc", 32'(out_pc), 32'd7);
        chk("redir_w7_instr", out_instr, 32'hC17C6279);
        step();
        @(negedge CLK);
        chk("redir_w0_pc", 32'(out_pc), 32'd0);
        chk("redir_w0_instr", out_instr, 32'hD82C07CD);
        step();

        // Reset mid-stream with three entries queued
        apply_reset(1'b0);
        repeat (3) step();
        @(negedge CLK);
        chk("mid_pre_count", 32'(count), 32'd3);
        RST_N     = 1'b0;
        out_ready = 1'b1;
        step();
        RST_N = 1'b1;
        @(negedge CLK);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_addr", 32'(rom_addr), 32'd0);
        step();
        @(negedge CLK);
        chk("mid_restart_valid", 32'(out_valid), 32'd1);
        chk("mid_restart_pc", 32'(out_pc), 32'd0);
        step();
`else
        // Zero-latency word on the first cycle after reset release
        apply_reset(1'b0);
        @(negedge CLK);
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_pc", 32'(out_pc), 32'd0);
        chk("byp_instr", out_instr, 32'hD82C07CD);
        step();
`endif

        // Random back-pressure and occasional redirects against the model
        apply_reset(1'b0);
        mq.delete();
        mpc = 3'd0;
        for (int c = 0; c < 1000; c++) begin
            out_ready      = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc    = 3'($urandom_range(0, 7));
            @(negedge CLK);
            model_check();
            @(posedge CLK);
            model_edge();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch stage sitting directly upstream of the instruction-fetch ROM lookup. It owns the program counter, drives the ROM address each cycle and captures the combinationally returned word. Fetched words are held with their PCs in a small FIFO and handed to the decode side over a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new PC.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `AW`, 3: PC / ROM address width.
- `DW`, 32: instruction width.
- `CW`, 3: occupancy width, equal to clog2(DEPTH+1).
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `rom_addr` out AW: fetch address. Equals the `pc` register, combinational from it.
- `rom_data` in DW: word at `rom_addr`, valid in the same cycle.
- `redirect_valid` in 1: flush the queue and restart fetch.
- `redirect_pc` in AW: new PC; sampled when `redirect_valid` is 1.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts the head entry.
- `out_instr` out DW: head instruction; 0 when `out_valid` is 0.
- `out_pc` out AW: head PC; 0 when `out_valid` is 0.
- `count` out CW: current FIFO occupancy.

## Operation
- State:
  - `pc` register.
  - Circular buffer of DEPTH {pc, instr} entries.
  - Read pointer and write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy `count`.
- deq = `out_valid & out_ready`.
- enq = !`redirect_valid` & (`count` < DEPTH | deq).
- On enq: write {`pc`, `rom_data`} at the write pointer; write pointer +1; `pc` <= `pc`+1, wrapping modulo 2^AW (7 -> 0 for AW=3).
- On deq: read pointer +1.
- `count` update: `count` + enq - deq. A simultaneous enq and deq leaves `count` unchanged.
- Full (`count`=DEPTH) with no deq: no enq; `pc` and `rom_addr` hold.
- Empty: `out_valid`=0, `out_instr`=0, `out_pc`=0.
- Redirect has priority over all other updates:
  - Pointers and `count` clear to 0; `pc` <= `redirect_pc`; no enq that cycle.
  - A deq in the redirect cycle counts as completed; the entry is discarded from the queue.
- Reset (RST_N=0 at an edge), valid at any time including mid-stream:
  - `pc`=0, pointers=0, `count`=0.
  - Outputs after reset: `out_valid`=0, `out_instr`=0, `out_pc`=0, `rom_addr`=0.
  - FIFO storage contents are don't-care.

## Timing
- `rom_addr` changes only after a clock edge.
- `rom_data` is used in the same cycle; no ROM latency is modelled.
- Without bypass: a word fetched in cycle N appears on `out_*` in cycle N+1.
- Sustained throughput is 1 word/cycle while the consumer holds `out_ready`=1.
- First word after reset release: `out_valid`=1 one cycle after the first edge with `RST_N`=1.
- After a redirect edge: `rom_addr`=`redirect_pc` in the next cycle; its word is valid one cycle later (bypass off).
- `out_valid` never depends combinationally on `out_ready`.

## Configuration
- `INSTR_PREFETCH_BYPASS_EN` defined:
  - When `count`=0 and `redirect_valid`=0: `out_valid`=1, `out_instr`=`rom_data`, `out_pc`=`pc`, all combinational.
  - If `out_ready`=1 in that case, the word is consumed directly: not enqueued, `pc` advances.
  - Result: zero-cycle latency from `rom_addr` to the consumer when the queue is empty.
- Macro undefined: no bypass; `out_*` are driven only from FIFO storage; latency is as in Timing.

## Test plan
Bench ROM model: word0=32'hD82C07CD, word1=32'h6BAA9455, word7=32'hC17C6279.
- Reset then run with `out_ready`=1 -> `out_pc` sequence 0,1,2,…,7,0 on consecutive cycles; `out_instr` for pc 0 = 32'hD82C07CD.
- `out_ready`=0 for 10 cycles -> `count` saturates at 4, `rom_addr` holds at 4. Then `out_ready`=1 -> `out_pc` 0,1,2,3,4,… with no gap and no duplicates.
- At full, pulse `redirect_valid` with `redirect_pc`=7 in the same cycle as a deq -> next cycle `count`=0 and `rom_addr`=7. Following cycle `out_pc`=7, `out_instr`=32'hC17C6279; then `out_pc`=0, `out_instr`=32'hD82C07CD.
- Assert `RST_N`=0 for one edge while `count`=3 -> `count`=0, `out_valid`=0, `rom_addr`=0 immediately after the edge; stream restarts at pc 0.
- Random `out_ready` (50%) for 1000 cycles -> scoreboard: each `out_pc` = previous+1 mod 8, `out_instr` matches ROM[`out_pc`], `count` stays ≤4.
- With `INSTR_PREFETCH_BYPASS_EN` defined: first cycle after reset release shows `out_valid`=1, `out_pc`=0, `out_instr`=32'hD82C07CD.
